// File: rtl/frequency_pkg.sv
// -----------------------------------------------------------------------------
// frequency_pkg
// Shared types and constants for the frequency_bank clock/tick generator.
//   mode_e       : per-channel output mode (square clock or one-cycle pulse)
//   chan_state_e : per-channel FSM state (IDLE / RUN)
//   DEF_CNT_W, DEF_DEFAULT_DIV : default counter width and reset divisor
//   clamp_div()  : maps a divisor of 0 to 1 so a period is never empty
// -----------------------------------------------------------------------------
package frequency_pkg;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_e;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_DEFAULT_DIV = 500;

    // A divisor of zero would never wrap; treat it as the fastest rate.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/frequency_channel.sv
// -----------------------------------------------------------------------------
// frequency_channel
// One divider channel: IDLE/RUN FSM, period counter, pending-divisor register
// and registered outputs.
// Ports:
//   clk_50    in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   run enable (level)
//   mode      in   0 = square clock, 1 = pulse
//   wr        in   divisor write strobe for this channel (one cycle)
//   wr_data   in   divisor value written
//   clk_out   out  divided output (square, or equal to tick in pulse mode)
//   tick      out  one-cycle pulse at each period boundary
//   state_dbg out  current FSM state
// -----------------------------------------------------------------------------
module frequency_channel
    import frequency_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DEFAULT_DIV = DEF_DEFAULT_DIV
) (
    input  logic             clk_50,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_data,
    output logic             clk_out,
    output logic             tick,
    output chan_state_e      state_dbg
);

    localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(clamp_div(32'(DEFAULT_DIV)));
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    chan_state_e      state, state_nxt;
    mode_e            mode_now;
    mode_e            eff_mode, eff_mode_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] active_div, active_div_nxt;
    logic [CNT_W-1:0] pend_div, pend_div_nxt;
    logic             pend_valid, pend_valid_nxt;
    logic             clk_out_nxt, tick_nxt;
    logic [CNT_W-1:0] wr_div;
    logic             wrap;

    assign mode_now  = mode_e'(mode);
    assign wr_div    = CNT_W'(clamp_div(32'(wr_data)));
    assign wrap      = (state == RUN) && (cnt == active_div - ONE);
    assign state_dbg = state;

    // State register
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en)  state_nxt = RUN;
            RUN:     if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        cnt_nxt        = cnt;
        clk_out_nxt    = clk_out;
        tick_nxt       = 1'b0;
        active_div_nxt = active_div;
        pend_div_nxt   = pend_div;
        pend_valid_nxt = pend_valid;
        eff_mode_nxt   = eff_mode;

        if (state == IDLE || state_nxt == IDLE) begin
            // Idle, or being stopped this cycle: no partial period completes.
            // A divisor still pending when the channel stops is applied here,
            // since with no period running there is nothing left to protect.
            cnt_nxt        = '0;
            clk_out_nxt    = 1'b0;
            eff_mode_nxt   = mode_now;
            pend_valid_nxt = 1'b0;
            if (wr) begin
                active_div_nxt = wr_div;
            end else if (pend_valid) begin
                active_div_nxt = pend_div;
            end
        end else if (wrap) begin
            // Period boundary: new mode and any new divisor take effect here.
            cnt_nxt        = '0;
            tick_nxt       = 1'b1;
            eff_mode_nxt   = mode_now;
            clk_out_nxt    = (mode_now == MODE_PULSE) ? 1'b1 : ~clk_out;
            pend_valid_nxt = 1'b0;
            if (wr) begin
                active_div_nxt = wr_div;
            end else if (pend_valid) begin
                active_div_nxt = pend_div;
            end
        end else begin
            // Mid-period: the running period keeps its divisor; a write is
            // parked (a later write overwrites it). In square mode clk_out
            // holds; a pulse is only ever one cycle wide.
            cnt_nxt = cnt + ONE;
            if (eff_mode == MODE_PULSE) begin
                clk_out_nxt = 1'b0;
            end
            if (wr) begin
                pend_div_nxt   = wr_div;
                pend_valid_nxt = 1'b1;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
            active_div <= RESET_DIV;
            pend_div   <= '0;
            pend_valid <= 1'b0;
            eff_mode   <= MODE_SQUARE;
        end else begin
            cnt        <= cnt_nxt;
            clk_out    <= clk_out_nxt;
            tick       <= tick_nxt;
            active_div <= active_div_nxt;
            pend_div   <= pend_div_nxt;
            pend_valid <= pend_valid_nxt;
            eff_mode   <= eff_mode_nxt;
        end
    end

endmodule

// File: rtl/frequency_bank.sv
// -----------------------------------------------------------------------------
// frequency_bank
// Multi-channel programmable clock/tick generator running from clk_50. Each
// channel has its own divisor, enable and output mode.
// Optional build macro: FREQ_SYNC_EN -- when defined, each en bit passes
// through a two-flop synchronizer before its channel (start/stop latency +2).
// Ports:
//   clk_50    in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   per-channel run enable (level)
//   mode      in   per-channel mode: 0 = square clock, 1 = pulse
//   div_wr    in   divisor write strobe
//   div_sel   in   channel addressed by div_wr
//   div_data  in   divisor value written
//   clk_out   out  per-channel divided output
//   tick      out  per-channel one-cycle pulse at each period boundary
//   state_dbg out  per-channel FSM state (1 = RUN)
// Write interface: div_wr is a single-cycle strobe with no back-pressure; a
// write is taken in the cycle div_wr is high and div_sel names an existing
// channel, otherwise it is dropped.
// -----------------------------------------------------------------------------
module frequency_bank
    import frequency_pkg::*;
#(
    parameter  int CHANNELS    = 2,
    parameter  int CNT_W       = DEF_CNT_W,
    parameter  int DEFAULT_DIV = DEF_DEFAULT_DIV,
    localparam int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_50,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] en,
    input  logic [CHANNELS-1:0] mode,
    input  logic                div_wr,
    input  logic [SEL_W-1:0]    div_sel,
    input  logic [CNT_W-1:0]    div_data,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] state_dbg
);

    logic [CHANNELS-1:0] en_int;
    logic [CHANNELS-1:0] ch_wr;

    // Write decode; out-of-range selects match no channel.
    always_comb begin
        ch_wr = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ch_wr[c] = div_wr && (32'(div_sel) == 32'(c));
        end
    end

`ifdef FREQ_SYNC_EN
    logic [CHANNELS-1:0] en_meta;
    logic [CHANNELS-1:0] en_sync;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            en_meta <= '0;
            en_sync <= '0;
        end else begin
            en_meta <= en;
            en_sync <= en_meta;
        end
    end

    assign en_int = en_sync;
`else
    assign en_int = en;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        chan_state_e ch_state;

        frequency_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_50    (clk_50),
            .rst_n     (rst_n),
            .en        (en_int[g]),
            .mode      (mode[g]),
            .wr        (ch_wr[g]),
            .wr_data   (div_data),
            .clk_out   (clk_out[g]),
            .tick      (tick[g]),
            .state_dbg (ch_state)
        );

        assign state_dbg[g] = (ch_state == RUN);
    end

endmodule

// File: doc/frequency_bank.md
Name: frequency_bank

Overview:
- Multi-channel programmable clock/tick generator driven from clk_50; successor of the single-rate elevator frequency divider.
- Each channel has its own runtime-writable divisor, enable and output mode (square clock or one-cycle tick).
- Feeds the elevator controller's floor-travel timer, door timer and display refresh from one block.

Parameters:
- CHANNELS, 2, number of independent divider channels (>=1)
- CNT_W, 16, width of divisor and counter
- DEFAULT_DIV, 500, divisor loaded into every channel at reset (clk_50 cycles per output half-period/tick period)

Ports:
- clk_50  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  CHANNELS  per-channel run enable (level)
- mode  in  CHANNELS  per-channel mode: 0 = square clock, 1 = pulse
- div_wr  in  1  divisor write strobe, one cycle
- div_sel  in  max(1,clog2(CHANNELS))  channel addressed by div_wr
- div_data  in  CNT_W  divisor value written
- clk_out  out  CHANNELS  per-channel divided output
- tick  out  CHANNELS  per-channel one-cycle pulse at each period boundary

Behaviour:
- Reset (async, rst_n=0): every channel state=IDLE, cnt=0, active_div=DEFAULT_DIV, pending invalid, clk_out=0, tick=0. All outputs are registered.
- Per-channel FSM, IDLE and RUN:
  - IDLE: cnt=0, clk_out=0, tick=0. en sampled 1 -> RUN with cnt=0.
  - RUN: cnt increments each cycle. When cnt==active_div-1 (wrap): cnt->0, tick=1 for exactly one cycle.
  - Square mode (mode=0): clk_out toggles at each wrap; period = 2*active_div cycles.
  - Pulse mode (mode=1): clk_out equals tick.
  - en sampled 0 in RUN -> IDLE next cycle; clk_out and tick forced 0, cnt cleared, no partial period completes.
- Latency: first tick is high div cycles after the edge at which en is first sampled 1 (div=500 -> cycle 500).
- Divisor 0 is treated as 1. div=1: tick constantly high in RUN; square clk_out = clk_50/2.
- Divisor write (div_wr=1, div_sel<CHANNELS):
  - Channel IDLE: active_div updated immediately.
  - Channel RUN: value held as pending and applied at the next wrap; the current period completes with the old value.
  - Write in the same cycle as a wrap: applied at that wrap.
  - Second write before a wrap overwrites pending.
  - div_sel>=CHANNELS: write ignored.
- mode is sampled continuously. A change in RUN takes effect at the next wrap; clk_out is held at its value until then. A change in IDLE takes effect immediately.
- Channels are fully independent; simultaneous wraps on several channels are legal.
- Reset asserted mid-period: outputs go to 0 asynchronously and pending writes are discarded.

Optional Feature:
- Macro FREQ_SYNC_EN.
- Defined: en passes through a two-flop synchronizer per channel (reset to 0) before the FSM; start/stop latency grows by 2 cycles (first tick at div+2).
- Undefined: en is used directly; the latency above applies.

Decomposition:
- Package frequency_pkg:
  - mode enum (MODE_SQUARE=0, MODE_PULSE=1)
  - state enum (IDLE, RUN)
  - default CNT_W/DEFAULT_DIV constants
  - divisor-0-to-1 clamp function
- Sub-module frequency_channel: one FSM, counter, pending register and output flops, instantiated CHANNELS times via generate.
- The top level holds write decode and the optional synchronizer.

Test Plan:
- Reset then en[0]=1, mode=0, div=500 -> tick[0] high at cycles 500, 1000, 1500; clk_out[0] toggles at each, period 1000; channel 1 (en=0) stays 0.
- Pulse mode, div_wr sel=1 data=4 while IDLE, en[1]=1 -> clk_out[1]=tick[1] high one cycle every 4 cycles.
- Running div=10, write 3 at cnt=5 -> wraps at 10, then every 3; write coincident with wrap -> new value used for next period.
- div=0 and div=1 -> tick continuous; square clk_out toggles every cycle.
- en dropped mid-period (cnt=200, div=500) -> next cycle clk_out=0, tick=0, no tick; re-enable gives first tick 500 cycles later.
- rst_n pulsed low mid-run with pending write -> outputs 0 immediately; after release active_div=500 and the pending write is lost. With FREQ_SYNC_EN defined, first tick lands at cycle 502.
